// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types, default primitive taps and parity helper for the PRBS block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prbs_pkg;

  // Checker lock state; locked output is (state == LOCKED).
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Feedback masks for a left-shifting Fibonacci LFSR: bit i set puts state[i] in the XOR.
  // Each corresponds to a primitive polynomial, giving period 2^WIDTH-1.
  localparam logic [4:0]  TAPS_W5  = 5'b10100;          // x^5  + x^3  + 1
  localparam logic [6:0]  TAPS_W7  = 7'b1100000;        // x^7  + x^6  + 1
  localparam logic [8:0]  TAPS_W9  = 9'b100010000;      // x^9  + x^5  + 1
  localparam logic [14:0] TAPS_W15 = 15'h6000;          // x^15 + x^14 + 1
  localparam logic [22:0] TAPS_W23 = 23'h420000;        // x^23 + x^18 + 1
  localparam logic [30:0] TAPS_W31 = 31'h48000000;      // x^31 + x^28 + 1

  // Default taps for a given length; widths not listed must pass TAPS explicitly.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      5:       return 32'(TAPS_W5);
      7:       return 32'(TAPS_W7);
      9:       return 32'(TAPS_W9);
      15:      return 32'(TAPS_W15);
      23:      return 32'(TAPS_W23);
      31:      return 32'(TAPS_W31);
      default: return 32'(TAPS_W5);
    endcase
  endfunction

  // XOR of the bits of v selected by mask m; shared by generator and checker.
  function automatic logic masked_parity(input logic [31:0] v, input logic [31:0] m);
    return ^(v & m);
  endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if: control, generator and checker signals of the PRBS block.
// Latency: n/a (wiring only).
// Backpressure: none; en and chk_valid qualify individual bits. err_inject exists only with PRBS_ERR_INJECT_EN.
interface prbs_gen_chk_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16
);
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             gen_bit;
  logic             gen_valid;
  logic [WIDTH-1:0] gen_state;
  logic             chk_in;
  logic             chk_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_ERR_INJECT_EN
  logic             err_inject;
`endif

  // Side that drives stimulus and observes status (link controller or bench).
  modport master (
`ifdef PRBS_ERR_INJECT_EN
    output err_inject,
`endif
    output en, seed_load, seed, chk_in, chk_valid, clr_cnt,
    input  gen_bit, gen_valid, gen_state, locked, err_pulse, err_cnt
  );

  // The PRBS block itself.
  modport slave (
`ifdef PRBS_ERR_INJECT_EN
    input  err_inject,
`endif
    input  en, seed_load, seed, chk_in, chk_valid, clr_cnt,
    output gen_bit, gen_valid, gen_state, locked, err_pulse, err_cnt
  );

endinterface

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker with lock FSM and saturating error counter.
// Latency: locked/err_pulse/err_cnt update one cycle after the chk_valid cycle that causes them.
// Backpressure: none; cycles with chk_valid=0 freeze the checker.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter int               LOCK_CNT = 10,
  parameter int               LOSS_THR = 4,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_in,
  input  logic             chk_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THR + 1);
  // Counter values on which the next event completes the run.
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_THR - 1);

  chk_state_t         state;
  logic [WIDTH-1:0]   chk_reg;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               pred;
  logic               miss;

  // Predict the incoming bit from the last WIDTH received bits; an all-zero
  // history cannot come from a running LFSR, so it always counts as a miss.
  always_comb begin
    pred = masked_parity(32'(chk_reg), 32'(TAPS));
    miss = (chk_in != pred) || (chk_reg == '0);
  end

  // History shift register, lock FSM, run counters and error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      chk_reg   <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (chk_valid) begin
        // History always comes from the received stream, which makes the checker self-synchronising.
        chk_reg <= {chk_reg[WIDTH-2:0], chk_in};
        case (state)
          SEARCH: begin
            if (miss) begin
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (miss) begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
              end
              if (miss_cnt == LOSS_LAST) begin
                state     <= SEARCH;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Clear overrides a same-cycle increment; the pulse above still fires.
      if (clr_cnt) begin
        err_cnt <= '0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: seedable Fibonacci-LFSR PRBS generator plus independent self-synchronising checker.
// Latency: gen_bit/gen_valid one cycle after the en cycle; checker status one cycle after chk_valid.
// Backpressure: none; en/chk_valid qualify each bit. Macro PRBS_ERR_INJECT_EN adds bus.err_inject.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter int               LOCK_CNT = 10,
  parameter int               LOSS_THR = 4,
  parameter int               CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  prbs_gen_chk_if.slave  bus
);

  localparam logic [WIDTH-1:0] STATE_INIT = WIDTH'(1);

  logic [WIDTH-1:0] state;
  logic             gen_bit_q;
  logic             gen_valid_q;
  logic             fb;
  logic             inj_bit;

  assign fb = masked_parity(32'(state), 32'(TAPS));

`ifdef PRBS_ERR_INJECT_EN
  // Inversion only touches the emitted bit, so the sequence itself stays intact.
  assign inj_bit = bus.err_inject;
`else
  assign inj_bit = 1'b0;
`endif

  // Generator: seed load has priority over stepping; a zero seed is replaced
  // with the reset state so the LFSR can never lock up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STATE_INIT;
      gen_bit_q   <= 1'b0;
      gen_valid_q <= 1'b0;
    end else if (bus.seed_load) begin
      state       <= (bus.seed == '0) ? STATE_INIT : bus.seed;
      gen_valid_q <= 1'b0;
    end else if (bus.en) begin
      gen_bit_q   <= state[WIDTH-1] ^ inj_bit;
      gen_valid_q <= 1'b1;
      state       <= {state[WIDTH-2:0], fb};
    end else begin
      gen_valid_q <= 1'b0;
    end
  end

  assign bus.gen_bit   = gen_bit_q;
  assign bus.gen_valid = gen_valid_q;
  assign bus.gen_state = state;

  prbs_chk #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_THR (LOSS_THR),
    .CNT_W    (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .chk_in    (bus.chk_in),
    .chk_valid (bus.chk_valid),
    .clr_cnt   (bus.clr_cnt),
    .locked    (bus.locked),
    .err_pulse (bus.err_pulse),
    .err_cnt   (bus.err_cnt)
  );

endmodule
